// File: rtl/ps2_keycode_decoder.sv
// PS/2 keyboard receiver: deserialises 11-bit frames, checks parity/stop/timeout,
// and turns set-2 make/break sequences for the game keys into a held ASCII keyCode.
module ps2_keycode_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 65000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [6:0] keyCode,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, clk_prev;
  logic          dat_s1, dat_s2;
  logic          strobe;
  logic          bit_q;
  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic          byte_vld;
  logic [7:0]    byte_q;
  logic          brk, ext;
  logic [6:0]    byte_ascii;
  logic          byte_mapped;

  function automatic logic [6:0] map_ascii(input logic [7:0] sc);
    case (sc)
      8'h1C:   map_ascii = 7'h61;
      8'h23:   map_ascii = 7'h64;
      8'h1D:   map_ascii = 7'h77;
      8'h1B:   map_ascii = 7'h73;
      8'h29:   map_ascii = 7'h20;
      default: map_ascii = 7'h00;
    endcase
  endfunction

  assign byte_ascii  = map_ascii(byte_q);
  assign byte_mapped = (byte_ascii != 7'h00);

  // Synchronisers; the falling-edge strobe is registered together with the data bit
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
      strobe   <= 1'b0;
      bit_q    <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_data;
      dat_s2   <= dat_s1;
      strobe   <= clk_prev & ~clk_s2;
      bit_q    <= dat_s2;
    end
  end

  // Frame FSM, timeout watchdog and byte interpretation
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      par_bit   <= 1'b0;
      tcnt      <= '0;
      byte_vld  <= 1'b0;
      byte_q    <= 8'h00;
      brk       <= 1'b0;
      ext       <= 1'b0;
      keyCode   <= 7'h00;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_vld  <= 1'b0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;

      if (byte_vld) begin
        if (byte_q == 8'hE0) begin
          ext <= 1'b1;
        end else if (byte_q == 8'hF0) begin
          brk <= 1'b1;
        end else if (ext) begin
          ext <= 1'b0;
          brk <= 1'b0;
        end else if (brk) begin
          brk <= 1'b0;
          if (byte_mapped && byte_ascii == keyCode) begin
            keyCode   <= 7'h00;
            key_valid <= 1'b1;
          end
        end else if (byte_mapped) begin
          keyCode   <= byte_ascii;
          key_valid <= 1'b1;
        end
      end

      if (strobe || state == IDLE) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + TW'(1);
      end

      if (!strobe && state != IDLE && tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state     <= IDLE;
        frame_err <= 1'b1;
        brk       <= 1'b0;
        ext       <= 1'b0;
      end else if (strobe) begin
        case (state)
          IDLE: begin
            if (!bit_q) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end
          end
          DATA: begin
            shreg   <= {bit_q, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= bit_q;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (bit_q && (^{shreg, par_bit})) begin
              byte_vld <= 1'b1;
              byte_q   <= shreg;
            end else begin
              frame_err <= 1'b1;
              brk       <= 1'b0;
              ext       <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
